// File: rtl/lcd_status_reader_pkg.sv
// ----------------------------------------------------------------------------
// lcd_status_reader_pkg
// Shared definitions for the LCD read path: read FSM state encoding, request
// mode codes and the position of the busy flag in the status byte.
// These are also used by the write-side controller.
// ----------------------------------------------------------------------------
package lcd_status_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_E_HI  = 3'd2,
        S_E_LO  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_STATUS = 2'b00;
    localparam logic [1:0] MODE_DATA   = 2'b01;
    localparam logic [1:0] MODE_POLL   = 2'b10;

    // Busy flag position in the status byte; bits below it are the address counter.
    localparam int BF_BIT = 7;

endpackage

// File: rtl/lcd_status_reader_if.sv
// ----------------------------------------------------------------------------
// lcd_status_reader_if
// Request/response and LCD pin bundle for the status reader.
//   start/mode     : 1-cycle request and read type
//   db_in          : LCD DB pins as seen at the pad
//   E/RW/RS/bus_own: LCD control pins and bus ownership towards the top mux
//   ready/valid/timeout, rd_data/busy_flag/ac : status and results
// master = the reader, slave = the requester / bus side.
// ----------------------------------------------------------------------------
interface lcd_status_reader_if;
    logic       start;
    logic [1:0] mode;
    logic [7:0] db_in;
    logic       E;
    logic       RW;
    logic       RS;
    logic       bus_own;
    logic       ready;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic [6:0] ac;
    logic       valid;
    logic       timeout;

    modport master (
        input  start, mode, db_in,
        output E, RW, RS, bus_own, ready, rd_data, busy_flag, ac, valid, timeout
    );

    modport slave (
        output start, mode, db_in,
        input  E, RW, RS, bus_own, ready, rd_data, busy_flag, ac, valid, timeout
    );
endinterface

// File: rtl/lcd_status_reader_phase_timer.sv
// ----------------------------------------------------------------------------
// lcd_phase_timer
// Loadable down-counter timing the SETUP and E-high phases.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : load i_load_val (phase length minus one)
//   o_done         : counter at zero -> current cycle is the phase's last
// ----------------------------------------------------------------------------
module lcd_phase_timer #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)           r_cnt <= '0;
        else if (i_load)        r_cnt <= i_load_val;
        else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
    end

    assign o_done = (r_cnt == '0);
endmodule

// File: rtl/lcd_status_reader.sv
// ----------------------------------------------------------------------------
// lcd_status_reader
// Runs HD44780-style read cycles (RW=1) on the shared LCD bus: status read,
// data read, or polling of the busy flag until it clears or POLL_MAX reads.
//   clk_1ms : sole clock (1 ms tick)
//   reset   : synchronous active-low reset
//   bus     : request/result and LCD pin bundle (master side)
// ----------------------------------------------------------------------------
module lcd_status_reader
    import lcd_status_reader_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int E_HIGH_CYC = 1,
    parameter int POLL_MAX   = 50
) (
    input  logic                 clk_1ms,
    input  logic                 reset,
    lcd_status_reader_if.master  bus
);
    localparam int CNT_W   = $clog2(POLL_MAX + 1);
    localparam int MAX_CYC = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] EHI_LD   = TMR_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX);

    state_t            r_state, w_next;
    logic [1:0]        r_mode, w_mode;
    logic [CNT_W-1:0]  r_poll_cnt, w_cnt_inc;
    logic              r_bf_smp;
    logic              w_tmr_load, w_tmr_done;
    logic [TMR_W-1:0]  w_tmr_val;
    logic              w_data_rd, w_poll, w_rd_phase;

    logic              r_e, r_rw, r_rs, r_own, r_ready, r_valid, r_timeout;
    logic [7:0]        r_rd_data;
    logic              r_busy;
    logic [6:0]        r_ac;

    lcd_phase_timer #(.W(TMR_W)) u_timer (
        .i_clk      (clk_1ms),
        .i_rst_n    (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // On the accepting edge the requested mode is not latched yet, so the
    // registered RS for the first SETUP cycle must come from the request.
    always_comb begin
        w_mode = r_mode;
        if (r_state == S_IDLE)
            w_mode = (bus.mode == 2'b11) ? MODE_STATUS : bus.mode;
    end

    assign w_data_rd = (w_mode == MODE_DATA);
    assign w_poll    = (r_mode == MODE_POLL);
    // Completed-read count including the read ending now; saturates.
    assign w_cnt_inc = (r_poll_cnt == POLL_LIM) ? r_poll_cnt : r_poll_cnt + CNT_W'(1);
    assign w_rd_phase = (w_next == S_SETUP) || (w_next == S_E_HI) || (w_next == S_E_LO);

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = SETUP_LD;
        unique case (r_state)
            S_IDLE:  if (bus.start) begin
                         w_next     = S_SETUP;
                         w_tmr_load = 1'b1;
                     end
            S_SETUP: if (w_tmr_done) begin
                         w_next     = S_E_HI;
                         w_tmr_load = 1'b1;
                         w_tmr_val  = EHI_LD;
                     end
            S_E_HI:  if (w_tmr_done) w_next = S_E_LO;
            S_E_LO:  if (w_poll && r_bf_smp && (w_cnt_inc < POLL_LIM)) begin
                         w_next     = S_SETUP;
                         w_tmr_load = 1'b1;
                     end else begin
                         w_next = S_DONE;
                     end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mode     <= MODE_STATUS;
            r_poll_cnt <= '0;
            r_bf_smp   <= 1'b0;
            r_e        <= 1'b0;
            r_rw       <= 1'b0;
            r_rs       <= 1'b0;
            r_own      <= 1'b0;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
            r_ac       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_mode     <= w_mode;
                r_poll_cnt <= '0;
            end
            if (r_state == S_E_LO)
                r_poll_cnt <= w_cnt_inc;
            if (r_state == S_E_HI && w_tmr_done) begin
                r_rd_data <= bus.db_in;
                r_bf_smp  <= bus.db_in[BF_BIT];
                if (!w_data_rd) begin
                    r_busy <= bus.db_in[BF_BIT];
                    r_ac   <= bus.db_in[BF_BIT-1:0];
                end
            end
            // Pins follow the next state so that they change only on phase boundaries.
            r_e       <= (w_next == S_E_HI);
            r_rw      <= w_rd_phase;
            r_own     <= w_rd_phase;
            r_rs      <= w_rd_phase && w_data_rd;
            r_ready   <= (w_next == S_IDLE);
            r_valid   <= (w_next == S_DONE);
            r_timeout <= (w_next == S_DONE) && w_poll && r_bf_smp;
        end
    end

    assign bus.E         = r_e;
    assign bus.RW        = r_rw;
    assign bus.RS        = r_rs;
    assign bus.bus_own   = r_own;
    assign bus.ready     = r_ready;
    assign bus.valid     = r_valid;
    assign bus.timeout   = r_timeout;
    assign bus.rd_data   = r_rd_data;
    assign bus.busy_flag = r_busy;
    assign bus.ac        = r_ac;
endmodule

// File: tb/tb_lcd_status_reader.sv
module tb_lcd_status_reader;
    localparam int P_SETUP = 1;
    localparam int P_EHI   = 1;
    localparam int P_POLL  = 5;

    logic clk_1ms = 1'b0;
    logic reset   = 1'b0;
    always #5 clk_1ms = ~clk_1ms;

    lcd_status_reader_if bus();

    lcd_status_reader #(.SETUP_CYC(P_SETUP), .E_HIGH_CYC(P_EHI), .POLL_MAX(P_POLL)) dut (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .bus     (bus)
    );

    // ctl = {E, RW, RS, bus_own, ready, valid, timeout}
    typedef struct packed {
        logic [6:0] ctl;
        logic       chk;
        logic [7:0] rd;
        logic       bf;
        logic [6:0] ac;
    } exp_t;

    int         n_pass = 0;
    int         n_chk  = 0;
    int         e_rises = 0;
    int         e_falls = 0;
    int         rd_base = 0;
    int         nbf     = 0;
    logic [7:0] fin     = 8'h00;
    bit         chk_en  = 1'b0;
    logic       mon_pe  = 1'b0;

    exp_t       q[$];
    logic [7:0] m_rd = 8'h00;
    logic       m_bf = 1'b0;
    logic [6:0] m_ac = 7'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // LCD model: reports BF=1 (byte AA) for the first nbf reads of an op, then fin.
    always_comb bus.db_in = ((e_falls - rd_base) < nbf) ? 8'hAA : fin;

    always @(negedge clk_1ms) begin
        if (!mon_pe && bus.E === 1'b1) e_rises <= e_rises + 1;
        if (mon_pe && bus.E === 1'b0)  e_falls <= e_falls + 1;
        mon_pe <= (bus.E === 1'b1);
    end

    // Model: an accepted request expands into its per-cycle pin timeline.
    task automatic push_op(input logic [1:0] md);
        int         reads;
        logic       rs;
        logic       poll;
        logic       to;
        logic [7:0] last;
        exp_t       e;
        poll  = (md == 2'b10);
        rs    = (md == 2'b01);
        reads = poll ? ((nbf + 1 < P_POLL) ? nbf + 1 : P_POLL) : 1;
        e = '0;
        for (int r = 0; r < reads; r++) begin
            for (int i = 0; i < P_SETUP; i++) begin
                e.ctl = {1'b0, 1'b1, rs, 1'b1, 3'b000}; q.push_back(e);
            end
            for (int i = 0; i < P_EHI; i++) begin
                e.ctl = {1'b1, 1'b1, rs, 1'b1, 3'b000}; q.push_back(e);
            end
            e.ctl = {1'b0, 1'b1, rs, 1'b1, 3'b000}; q.push_back(e);
        end
        last = (reads - 1 < nbf) ? 8'hAA : fin;
        m_rd = last;
        if (!rs) begin
            m_bf = last[7];
            m_ac = last[6:0];
        end
        to = poll && last[7];
        e.ctl = {4'b0000, 1'b0, 1'b1, to};
        e.chk = 1'b1;
        e.rd  = m_rd;
        e.bf  = m_bf;
        e.ac  = m_ac;
        q.push_back(e);
    endtask

    // Compare process: every cycle, DUT pins against the model timeline.
    initial begin : cmp
        exp_t x;
        logic p_e   = 1'b0;
        logic p_rw  = 1'b0;
        logic p_rs  = 1'b0;
        logic p_rst = 1'b0;
        forever begin
            @(negedge clk_1ms);
            if (chk_en) begin
                if (q.size() > 0) x = q.pop_front();
                else x = '{7'b0000100, 1'b1, m_rd, m_bf, m_ac};
                chk("ctl{E,RW,RS,own,rdy,vld,to}",
                    {bus.E, bus.RW, bus.RS, bus.bus_own, bus.ready, bus.valid, bus.timeout}, x.ctl);
                if (x.chk)
                    chk("data{rd,bf,ac}", {bus.rd_data, bus.busy_flag, bus.ac}, {x.rd, x.bf, x.ac});
                if (p_rst) begin
                    if (p_e && bus.E) chk("rw_rs_hold_while_E", {bus.RW, bus.RS}, {p_rw, p_rs});
                    if (p_e != bus.E) chk("rw_rs_stable_at_E_edge", {bus.RW, bus.RS}, {p_rw, p_rs});
                end
                if (!reset) begin
                    q.delete();
                    m_rd = 8'h00;
                    m_bf = 1'b0;
                    m_ac = 7'h00;
                end else if (bus.start && x.ctl[2]) begin
                    push_op(bus.mode);
                end
                p_e   = bus.E;
                p_rw  = bus.RW;
                p_rs  = bus.RS;
                p_rst = reset;
            end
        end
    end

    task automatic run_op(input logic [1:0] md, input int nb, input logic [7:0] fb,
                          input int lat, input int pulses, input logic [7:0] rd_exp,
                          input logic to_exp, input logic bf_exp, input logic [6:0] ac_exp);
        int cyc;
        int r0;
        @(posedge clk_1ms); #1;
        rd_base   = e_falls;
        r0        = e_rises;
        nbf       = nb;
        fin       = fb;
        bus.mode  = md;
        bus.start = 1'b1;
        @(posedge clk_1ms); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (bus.valid !== 1'b1 && cyc < 100) begin
            @(posedge clk_1ms); #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("e_pulses", e_rises - r0, pulses);
        chk("rd_data", bus.rd_data, rd_exp);
        chk("timeout", bus.timeout, to_exp);
        chk("busy_flag", bus.busy_flag, bf_exp);
        chk("ac", bus.ac, ac_exp);
    endtask

    initial begin : drv
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        repeat (2) @(posedge clk_1ms);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        chk("rst_ready", bus.ready, 1);
        chk("rst_bus_own", bus.bus_own, 0);
        chk("rst_rd_data", bus.rd_data, 0);

        // status, data, poll clearing after 3 busy reads, poll timeout
        run_op(2'b00, 0,    8'h45, 4,  1, 8'h45, 1'b0, 1'b0, 7'h45);
        run_op(2'b01, 0,    8'hC1, 4,  1, 8'hC1, 1'b0, 1'b0, 7'h45);
        run_op(2'b10, 3,    8'h12, 13, 4, 8'h12, 1'b0, 1'b0, 7'h12);
        run_op(2'b10, 1000, 8'h00, 16, 5, 8'hAA, 1'b1, 1'b1, 7'h2A);

        // reset while E is high; a second start mid-op must be ignored
        @(posedge clk_1ms); #1;
        rd_base   = e_falls;
        nbf       = 0;
        fin       = 8'h77;
        bus.mode  = 2'b00;
        bus.start = 1'b1;
        @(posedge clk_1ms); #1;
        bus.start = 1'b1;
        @(posedge clk_1ms); #1;
        bus.start = 1'b0;
        chk("E_before_reset", bus.E, 1);
        reset = 1'b0;
        @(posedge clk_1ms); #1;
        chk("E_after_reset", bus.E, 0);
        chk("own_after_reset", bus.bus_own, 0);
        chk("ready_after_reset", bus.ready, 1);
        chk("rd_after_reset", bus.rd_data, 0);
        reset = 1'b1;
        repeat (4) @(posedge clk_1ms);
        #1;

        // back-to-back: each start issued the cycle ready returns
        run_op(2'b00, 0, 8'h80, 4, 1, 8'h80, 1'b0, 1'b1, 7'h00);
        run_op(2'b11, 0, 8'h3C, 4, 1, 8'h3C, 1'b0, 1'b0, 7'h3C);
        run_op(2'b10, 0, 8'h05, 4, 1, 8'h05, 1'b0, 1'b0, 7'h05);
        run_op(2'b01, 0, 8'h9E, 4, 1, 8'h9E, 1'b0, 1'b0, 7'h05);

        repeat (5) @(posedge clk_1ms);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
